// File: rtl/key_debounce_if.sv
// Push-button bus between the raw key inputs and the debounced event outputs.
// Names follow the board-level signal names so the PUSH bits map directly onto the PWM controller.
interface key_debounce_if #(
    parameter int N = 4
);
    logic [N-1:0] KEY_N;
    logic         REPEAT_EN;
    logic [N-1:0] PUSH;
    logic [N-1:0] PRESS;
    logic [N-1:0] RELEASE;

    modport master (
        output KEY_N,
        output REPEAT_EN,
        input  PUSH,
        input  PRESS,
        input  RELEASE
    );

    modport slave (
        input  KEY_N,
        input  REPEAT_EN,
        output PUSH,
        output PRESS,
        output RELEASE
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer, debouncer and auto-repeat FSM, replicated once per channel.
// Channels are fully independent; only REPEAT_EN is shared.
module key_debounce_lane #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000,
    parameter int CW         = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_repeat_en,
    output logic o_push,
    output logic o_press,
    output logic o_release
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_REPEAT
    } state_t;

    localparam logic [CW-1:0] DEB_M1   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_M1 = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] PER_M1   = CW'(REP_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_deb_cnt;
    logic          r_push;
    logic [CW-1:0] r_rep_cnt;
    state_t        r_state;
    logic          r_press;
    logic          r_release;

    logic          w_sample;
    logic          w_diff;
    logic          w_deb_done;
    logic          w_fall;
    logic          w_rise;
    state_t        w_state_nx;
    logic [CW-1:0] w_rep_nx;
    logic          w_press_nx;
    logic          w_release_nx;

    assign w_sample   = r_sync[1];
    assign w_diff     = (w_sample != r_push);
    assign w_deb_done = w_diff && (r_deb_cnt >= DEB_M1);
    assign w_fall     = w_deb_done && !w_sample;
    assign w_rise     = w_deb_done && w_sample;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    // Counter runs only while the sample disagrees with PUSH; any agreement restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_deb_cnt <= '0;
            r_push    <= 1'b1;
        end else if (!w_diff) begin
            r_deb_cnt <= '0;
        end else if (w_deb_done) begin
            r_deb_cnt <= '0;
            r_push    <= w_sample;
        end else if (r_deb_cnt != CNT_MAX) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_rep_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rep_cnt <= w_rep_nx;
            r_press   <= w_press_nx;
            r_release <= w_release_nx;
        end
    end

    // A debounced release always wins over a repeat pulse due in the same cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_rep_nx     = r_rep_cnt;
        w_press_nx   = 1'b0;
        w_release_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rep_nx = '0;
                if (w_fall) begin
                    w_state_nx = S_HELD;
                    w_press_nx = 1'b1;
                end
            end
            S_HELD: begin
                if (w_rise) begin
                    w_state_nx   = S_IDLE;
                    w_rep_nx     = '0;
                    w_release_nx = 1'b1;
                end else if (!i_repeat_en) begin
                    w_rep_nx = '0;
                end else if (r_rep_cnt == DELAY_M1) begin
                    w_state_nx = S_REPEAT;
                    w_rep_nx   = '0;
                    w_press_nx = 1'b1;
                end else if (r_rep_cnt != CNT_MAX) begin
                    w_rep_nx = r_rep_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (w_rise) begin
                    w_state_nx   = S_IDLE;
                    w_rep_nx     = '0;
                    w_release_nx = 1'b1;
                end else if (!i_repeat_en) begin
                    w_rep_nx = '0;
                end else if (r_rep_cnt == PER_M1) begin
                    w_rep_nx   = '0;
                    w_press_nx = 1'b1;
                end else if (r_rep_cnt != CNT_MAX) begin
                    w_rep_nx = r_rep_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_rep_nx   = '0;
            end
        endcase
    end

    assign o_push    = r_push;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

module key_debounce #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic           CLK,
    input  logic           RST,
    key_debounce_if.slave  bus
);
    localparam int MAX_A = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
    localparam int MAX_V = (MAX_A > REP_PERIOD) ? MAX_A : REP_PERIOD;
    localparam int CW    = $clog2(MAX_V + 1);

    for (genvar g = 0; g < N; g++) begin : g_lane
        key_debounce_lane #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .CW         (CW)
        ) u_lane (
            .i_clk       (CLK),
            .i_rst       (RST),
            .i_key_n     (bus.KEY_N[g]),
            .i_repeat_en (bus.REPEAT_EN),
            .o_push      (bus.PUSH[g]),
            .o_press     (bus.PRESS[g]),
            .o_release   (bus.RELEASE[g])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with N=4, DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
// Expected pulse events are queued as stimulus is driven and matched against observed pulses.
module tb_key_debounce;
    logic CLK;
    logic RST;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   overlap;
    int   exp_q[$];
    int   obs_q[$];

    key_debounce_if #(.N(4)) bus ();

    key_debounce #(
        .N          (4),
        .DEB_CYCLES (4),
        .REP_DELAY  (10),
        .REP_PERIOD (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Event code: cycle*16 + channel*2 + (0 press / 1 release).
    always @(negedge CLK) begin
        if (!RST) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (bus.PRESS[ch])   obs_q.push_back(cyc * 16 + ch * 2);
                if (bus.RELEASE[ch]) obs_q.push_back(cyc * 16 + ch * 2 + 1);
            end
            if ((bus.PRESS & bus.RELEASE) != 4'b0000) overlap <= overlap + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        bus.KEY_N = 4'hF;
        bus.REPEAT_EN = 1'b0;
        #1;
        n_cmp++;
        if (bus.PUSH !== 4'hF || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_async: push=%b press=%b release=%b want 1111/0000/0000", bus.PUSH, bus.PRESS, bus.RELEASE);
        end
        tick(3);
        n_cmp++;
        if (bus.PUSH !== 4'hF || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_clocked: push=%b press=%b release=%b want 1111/0000/0000", bus.PUSH, bus.PRESS, bus.RELEASE);
        end
        RST = 1'b0;
        tick(8);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_no_pulse: got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_clean_press;
        int c;
        int e;
        int o;
        bus.REPEAT_EN = 1'b0;
        bus.KEY_N[0] = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 0);
        tick(5);
        n_cmp++;
        if (bus.PUSH[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_push_early: got %b want 1", bus.PUSH[0]);
        end
        tick(1);
        n_cmp++;
        if (bus.PUSH[0] !== 1'b0 || bus.PRESS[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_edge: push=%b press=%b want 0/1", bus.PUSH[0], bus.PRESS[0]);
        end
        tick(1);
        n_cmp++;
        if (bus.PRESS[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_one_cycle: press=%b want 0", bus.PRESS[0]);
        end
        tick(20);
        bus.KEY_N[0] = 1'b1;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 1);
        tick(10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL clean_event: got %0d want %0d", o, e);
            end
        end
    endtask

    task automatic test_bounce;
        int c;
        int e;
        int o;
        for (int i = 0; i < 2; i++) begin
            bus.KEY_N[1] = 1'b0;
            tick(3);
            bus.KEY_N[1] = 1'b1;
            tick(2);
        end
        bus.KEY_N[1] = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 2);
        tick(12);
        for (int i = 0; i < 2; i++) begin
            bus.KEY_N[1] = 1'b1;
            tick(3);
            bus.KEY_N[1] = 1'b0;
            tick(2);
        end
        bus.KEY_N[1] = 1'b1;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 3);
        tick(12);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL bounce_event: got %0d want %0d", o, e);
            end
        end
    endtask

    task automatic test_auto_repeat;
        int c;
        int e;
        int o;
        bus.REPEAT_EN = 1'b1;
        bus.KEY_N[2] = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 4);
        exp_q.push_back((c + 16) * 16 + 4);
        exp_q.push_back((c + 19) * 16 + 4);
        exp_q.push_back((c + 22) * 16 + 4);
        exp_q.push_back((c + 25) * 16 + 4);
        tick(22);
        // Release lands on the cycle a repeat would be due (c+28).
        bus.KEY_N[2] = 1'b1;
        exp_q.push_back((c + 28) * 16 + 5);
        tick(6);
        n_cmp++;
        if (bus.RELEASE[2] !== 1'b1 || bus.PRESS[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL repeat_release_priority: release=%b press=%b want 1/0", bus.RELEASE[2], bus.PRESS[2]);
        end
        tick(10);
        bus.REPEAT_EN = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL repeat_event: got %0d want %0d", o, e);
            end
        end
    endtask

    task automatic test_enable_toggle;
        int c;
        int e;
        int o;
        bus.REPEAT_EN = 1'b1;
        bus.KEY_N[2] = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 4);
        exp_q.push_back((c + 16) * 16 + 4);
        exp_q.push_back((c + 19) * 16 + 4);
        tick(20);
        bus.REPEAT_EN = 1'b0;
        tick(5);
        bus.REPEAT_EN = 1'b1;
        exp_q.push_back((c + 28) * 16 + 4);
        exp_q.push_back((c + 31) * 16 + 4);
        tick(7);
        bus.REPEAT_EN = 1'b0;
        bus.KEY_N[2] = 1'b1;
        exp_q.push_back((c + 38) * 16 + 5);
        tick(12);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL enable_event: got %0d want %0d", o, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int c;
        int e;
        int o;
        bus.REPEAT_EN = 1'b0;
        bus.KEY_N[0] = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 0);
        tick(8);
        bus.KEY_N[3] = 1'b0;
        tick(3);
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.PUSH !== 4'hF || bus.PRESS !== 4'h0 || bus.RELEASE !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_mid_async: push=%b press=%b release=%b want 1111/0000/0000", bus.PUSH, bus.PRESS, bus.RELEASE);
        end
        tick(2);
        RST = 1'b0;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 0);
        exp_q.push_back((c + 6) * 16 + 6);
        tick(5);
        n_cmp++;
        if (bus.PUSH !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_mid_early: push=%b want 1111", bus.PUSH);
        end
        tick(1);
        n_cmp++;
        if (bus.PRESS !== 4'b1001 || bus.PUSH !== 4'b0110) begin
            n_bad++;
            $display("FAIL reset_mid_repress: press=%b push=%b want 1001/0110", bus.PRESS, bus.PUSH);
        end
        tick(4);
        bus.KEY_N = 4'hF;
        c = cyc;
        exp_q.push_back((c + 6) * 16 + 1);
        exp_q.push_back((c + 6) * 16 + 7);
        tick(10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid_event: got %0d want %0d", o, e);
            end
        end
    endtask

    task automatic test_simultaneous;
        int c;
        int e;
        int o;
        bus.REPEAT_EN = 1'b0;
        bus.KEY_N = 4'h0;
        c = cyc;
        for (int ch = 0; ch < 4; ch++) exp_q.push_back((c + 6) * 16 + ch * 2);
        tick(6);
        n_cmp++;
        if (bus.PRESS !== 4'hF) begin
            n_bad++;
            $display("FAIL simul_press: got %b want 1111", bus.PRESS);
        end
        tick(1);
        n_cmp++;
        if (bus.PRESS !== 4'h0) begin
            n_bad++;
            $display("FAIL simul_press_clear: got %b want 0000", bus.PRESS);
        end
        tick(3);
        bus.KEY_N = 4'hF;
        c = cyc;
        for (int ch = 0; ch < 4; ch++) exp_q.push_back((c + 6) * 16 + ch * 2 + 1);
        tick(10);
        bus.KEY_N[1] = 1'b0;
        tick(2);
        bus.KEY_N[1] = 1'b1;
        tick(10);
        n_cmp++;
        if (bus.PUSH !== 4'hF) begin
            n_bad++;
            $display("FAIL glitch_push: got %b want 1111", bus.PUSH);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL simul_event: got %0d want %0d", o, e);
            end
        end
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL press_release_overlap: got %0d want 0", overlap);
        end
    endtask

    initial begin
        cyc = 0;
        n_cmp = 0;
        n_bad = 0;
        overlap = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_enable_toggle();
        test_reset_mid();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
- REQ-001 The block SHALL have parameter N, default 4: number of key channels.
- REQ-002 The block SHALL have parameter DEB_CYCLES, default 1_000_000: stable-cycle count for debounce (20 ms at 50 MHz).
- REQ-003 The block SHALL have parameter REP_DELAY, default 25_000_000: hold cycles before the first auto-repeat.
- REQ-004 The block SHALL have parameter REP_PERIOD, default 5_000_000: cycles between later auto-repeats.
- REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock, 50 MHz board clock.
- REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
- REQ-007 The block SHALL have port KEY_N, input, N bits: raw push-button levels, active-low, asynchronous to CLK.
- REQ-008 The block SHALL have port REPEAT_EN, input, 1 bit: global auto-repeat enable.
- REQ-009 The block SHALL have port PUSH, output, N bits: debounced level, active-low. This port feeds the PUSH input of the PWM controller.
- REQ-010 The block SHALL have port PRESS, output, N bits: one-cycle pulse per channel on a press or an auto-repeat.
- REQ-011 The block SHALL have port RELEASE, output, N bits: one-cycle pulse per channel on a release.

Function
- REQ-012 Each channel SHALL be processed independently. Identical logic per channel, no shared counters except the REPEAT_EN input.
- REQ-013 Each KEY_N bit SHALL pass through a 2-flop synchronizer. Synchronizer flops reset to 1.
- REQ-014 Debounce counter: it SHALL increment while the synchronized sample differs from PUSH. It SHALL clear to 0 on any cycle where the sample equals PUSH.
- REQ-015 PUSH SHALL take the sample value, and the counter SHALL clear, on the edge where the sample has differed for DEB_CYCLES consecutive cycles.
- REQ-016 Latency from a clean KEY_N transition to the PUSH transition SHALL be exactly DEB_CYCLES+2 cycles.
- REQ-017 A pulse or glitch on KEY_N lasting fewer than DEB_CYCLES synchronized cycles SHALL produce no change on PUSH, PRESS or RELEASE.
- REQ-018 Counter width SHALL be ceil(log2(max(DEB_CYCLES, REP_DELAY, REP_PERIOD)+1)) bits. Counters SHALL saturate and SHALL never wrap.
- REQ-019 PRESS SHALL assert for one cycle, registered, in the same cycle that PUSH goes 1->0.
- REQ-020 RELEASE SHALL assert for one cycle in the same cycle that PUSH goes 0->1.
- REQ-021 Each channel SHALL have a repeat FSM with states IDLE, HELD and REPEAT.
- REQ-022 IDLE -> HELD SHALL occur on a debounced press. The repeat counter SHALL clear on this transition.
- REQ-023 HELD -> REPEAT SHALL occur when the repeat counter reaches REP_DELAY-1 and REPEAT_EN=1. PRESS SHALL pulse in that cycle and the counter SHALL clear.
- REQ-024 In REPEAT, PRESS SHALL pulse and the counter SHALL clear each time the counter reaches REP_PERIOD-1.
- REQ-025 HELD or REPEAT -> IDLE SHALL occur on a debounced release. This SHALL take priority over a repeat pulse due in the same cycle: RELEASE=1, PRESS=0.
- REQ-026 While REPEAT_EN=0 in HELD or REPEAT, the repeat counter SHALL be held at 0, no repeat PRESS SHALL issue, and the state SHALL be retained.
- REQ-027 When REPEAT_EN returns to 1, counting SHALL restart from 0.
- REQ-028 PRESS and RELEASE for the same channel SHALL never be asserted together.
- REQ-029 Simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
- REQ-030 RST=1 SHALL immediately, without waiting for CLK, force: PUSH all 1s, PRESS=0, RELEASE=0, all counters 0, all FSMs IDLE, synchronizers all 1s.
- REQ-031 Reset asserted mid-debounce or mid-repeat SHALL discard all progress. No pulse SHALL be emitted on reset or on reset release.
- REQ-032 After RST deasserts with a key already held low, that key SHALL be treated as a new press: PRESS pulses DEB_CYCLES+2 cycles later.

Verification
Bench parameters: N=4, DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3.
- REQ-033 Clean press: KEY_N[0] 1->0 held, REPEAT_EN=0 -> PUSH[0]=0 and PRESS[0]=1 for 1 cycle, exactly 6 cycles after the edge. No further PRESS.
- REQ-034 Bounce: KEY_N[1] toggles with low phases of 3 cycles, then stays low -> exactly one PRESS[1]. Release handled the same way gives exactly one RELEASE[1].
- REQ-035 Auto-repeat: KEY_N[2] held low, REPEAT_EN=1 -> first PRESS at debounce, second 10 cycles later, then every 3 cycles. Release -> RELEASE[2] with no PRESS in the same cycle.
- REQ-036 Enable toggle: in REPEAT, drop REPEAT_EN for 5 cycles -> no PRESS. On re-enable, next PRESS comes 3 cycles later.
- REQ-037 Reset mid-operation: assert RST asynchronously during debounce on channel 3 -> outputs go to reset values before the next CLK edge. With KEY_N[3] still low after release, PRESS[3] comes 6 cycles later.
- REQ-038 Simultaneous events: all 4 keys pressed in the same cycle -> PRESS=4'b1111 for one cycle. Glitch of 2 cycles on a released key -> no outputs change.
